seg7_capture: RTL and testbench
===============================

# seg7_capture

Scan-side receiver for the multiplexed 4-digit seven-segment display bus: watches the active-low segment lines and active-low digit anodes driven by the display path. Reconstructs the four displayed BCD digits, with per-digit error flags and a frame-complete strobe. Used as a self-check monitor on the board-level display output and as the decode end in display loopback benches. It is the inverse of the BCD-to-segment encoding: segment bit 0 = a … bit 6 = g, and a 0 lights a segment.

## Interface
- STABLE_CYC, 4: consecutive identical registered samples required before a digit is accepted; legal range 2–255.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous, active-low.
- seg  input  7  segment lines, active-low, {g,f,e,d,c,b,a}.
- an  input  4  digit anodes, active-low; an[i]=0 selects digit i (digit 0 least significant).
- bcd  output  16  last complete frame, digit i in bcd[4i+3:4i].
- digit_err  output  4  per-digit error flag for the last complete frame.
- valid  output  1  high once at least one frame has completed since reset; sticky.
- frame_done  output  1  one-cycle pulse on each frame completion.

## Operation
- seg and an are registered once (s_seg, s_an). All logic works on registered values.
- Decode of s_seg:
  - The ten patterns 0–9 (0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000) decode to 4'h0–4'h9 with err=0.
  - 1111111 (blank) decodes to 4'hF with err=0.
  - Any other pattern decodes to 4'hF with err=1.
- FSM states:
  - IDLE: s_an not exactly one zero.
  - SETTLE: single digit selected, counting stable samples.
  - HELD: digit captured, waiting for a change.
- Stability counter cnt: reset to 1 whenever {s_an,s_seg} differs from the previous registered sample; otherwise saturating increment.
- Transitions:
  - Any change with s_an one-hot-low goes to SETTLE.
  - Any change with zero or multiple low bits goes to IDLE.
  - In SETTLE, cnt==STABLE_CYC triggers a capture and goes to HELD.
  - HELD with no change stays in HELD, so exactly one capture per dwell.
- Capture of digit i: writes the decoded value and err into staging slot i and sets seen[i]. A repeat capture of digit i in the same frame overwrites slot i.
- Frame completion, when a capture makes seen==4'hF:
  - On the same edge, the staging contents including the current digit are copied to bcd/digit_err.
  - frame_done=1 and valid=1.
  - seen is cleared to 0.
- No ordering of digits is required; any sequence covering all four completes a frame.

## Timing
- Reset values: bcd=16'hFFFF, digit_err=4'h0, valid=0, frame_done=0, seen=0, staging=all 4'hF/err 0, state IDLE, cnt=0.
- Capture latency: STABLE_CYC+1 rising edges after a new pattern is present at the pins (1 input register plus STABLE_CYC stable samples).
- bcd, digit_err and valid update on the completing capture edge. frame_done is high for exactly the following cycle.
- A dwell shorter than STABLE_CYC samples produces no capture.
- A glitch of one sample restarts the count from 1.
- Reset asserted mid-frame clears everything immediately. No partial frame survives.

## Structure
- Package seg7_pkg holds:
  - the ten digit segment constants and SEG_BLANK;
  - the FSM state enum (IDLE, SETTLE, HELD).
- Sub-module seg7_to_bcd: the purely combinational pattern decode, 7 bits in, 4-bit value and err out.
- Everything else lives in seg7_capture.

## Test plan
- Reset: hold rst_n=0 for 3 cycles mid-stimulus. Required: bcd=16'hFFFF, digit_err=0, valid=0, frame_done=0.
- Normal scan, STABLE_CYC=4: drive digits 0–3 with patterns for 3, 0, 9, 1, each for 10 cycles. Required: bcd=16'h1903, digit_err=0, one frame_done pulse, valid=1.
- Short dwell: digit 2 shown for only 3 cycles within the scan. Required: no frame_done. Frame completes on the next full dwell of digit 2.
- Invalid and blank patterns: digit 1 shows 0110110, digit 3 shows 1111111, the others show 5. Required: bcd=16'hF5F5, digit_err=4'b0010.
- Multi-anode and glitch: an=4'b0011 for 8 cycles gives no capture. A 1-cycle seg flip inside a 10-cycle dwell gives a capture only after 4 stable samples post-glitch.
- Out-of-order and repeat: digit order 2,0,0,3,1, with digit 0 changing from 7 to 8 between its two dwells. Required: bcd digit 0 is 4'h8. frame_done pulses once, on the digit-1 capture edge.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants and types for the seven-segment scan receiver.
// Segment bit 0 = a ... bit 6 = g, active-low.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HELD   = 2'd2
    } state_t;

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational segment-pattern to BCD decode.
// Blank decodes to F without error; unknown patterns flag err.
module seg7_to_bcd
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] val,
    output logic       err
);

    always_comb begin
        val = 4'hF;
        err = 1'b0;
        case (seg)
            SEG_0:     val = 4'h0;
            SEG_1:     val = 4'h1;
            SEG_2:     val = 4'h2;
            SEG_3:     val = 4'h3;
            SEG_4:     val = 4'h4;
            SEG_5:     val = 4'h5;
            SEG_6:     val = 4'h6;
            SEG_7:     val = 4'h7;
            SEG_8:     val = 4'h8;
            SEG_9:     val = 4'h9;
            SEG_BLANK: val = 4'hF;
            default: begin
                val = 4'hF;
                err = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/seg7_capture.sv
// Scan-side receiver for the multiplexed 4-digit seven-segment bus.
// Rebuilds the displayed BCD frame with per-digit error flags.
module seg7_capture
    import seg7_pkg::*;
#(
    parameter int unsigned STABLE_CYC = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  seg,
    input  logic [3:0]  an,
    output logic [15:0] bcd,
    output logic [3:0]  digit_err,
    output logic        valid,
    output logic        frame_done
);

    localparam logic [7:0] STABLE = 8'(STABLE_CYC);

    logic [6:0]  s_seg;
    logic [3:0]  s_an;
    logic [6:0]  p_seg;
    logic [3:0]  p_an;
    logic [7:0]  cnt;
    logic [7:0]  cnt_nxt;
    state_t      state;
    state_t      state_nxt;
    logic [15:0] stg_val;
    logic [3:0]  stg_err;
    logic [15:0] stg_val_nxt;
    logic [3:0]  stg_err_nxt;
    logic [3:0]  seen;
    logic [3:0]  seen_nxt;
    logic [1:0]  idx;
    logic        onehot;
    logic        change;
    logic        capture;
    logic        complete;
    logic [3:0]  dec_val;
    logic        dec_err;

    seg7_to_bcd u_dec (
        .seg (s_seg),
        .val (dec_val),
        .err (dec_err)
    );

    always_comb begin
        idx    = 2'd0;
        onehot = 1'b1;
        case (s_an)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: onehot = 1'b0;
        endcase
    end

    // cnt_nxt counts the current registered sample, so a capture
    // lands on the edge where the STABLE_CYC-th identical sample is seen.
    always_comb begin
        change = ({s_an, s_seg} != {p_an, p_seg});
        if (change)
            cnt_nxt = 8'd1;
        else if (cnt == 8'hFF)
            cnt_nxt = cnt;
        else
            cnt_nxt = cnt + 8'd1;
        capture = (state == SETTLE) && !change
                  && (cnt_nxt == STABLE);
    end

    always_comb begin
        state_nxt = state;
        if (change)
            state_nxt = onehot ? SETTLE : IDLE;
        else if (capture)
            state_nxt = HELD;
    end

    always_comb begin
        stg_val_nxt = stg_val;
        stg_err_nxt = stg_err;
        seen_nxt    = seen;
        if (capture) begin
            stg_val_nxt[{idx, 2'b00} +: 4] = dec_val;
            stg_err_nxt[idx]               = dec_err;
            seen_nxt[idx]                  = 1'b1;
        end
        complete = capture && (seen_nxt == 4'hF);
        if (complete)
            seen_nxt = 4'h0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_seg      <= SEG_BLANK;
            s_an       <= 4'hF;
            p_seg      <= SEG_BLANK;
            p_an       <= 4'hF;
            cnt        <= 8'd0;
            state      <= IDLE;
            stg_val    <= 16'hFFFF;
            stg_err    <= 4'h0;
            seen       <= 4'h0;
            bcd        <= 16'hFFFF;
            digit_err  <= 4'h0;
            valid      <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            s_seg      <= seg;
            s_an       <= an;
            p_seg      <= s_seg;
            p_an       <= s_an;
            cnt        <= cnt_nxt;
            state      <= state_nxt;
            stg_val    <= stg_val_nxt;
            stg_err    <= stg_err_nxt;
            seen       <= seen_nxt;
            frame_done <= complete;
            if (complete) begin
                bcd       <= stg_val_nxt;
                digit_err <= stg_err_nxt;
                valid     <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg7_capture.sv
// Directed bench for seg7_capture with STABLE_CYC=4.
// Inputs change on negedge, outputs sampled on negedge.
module tb_seg7_capture;

    localparam logic [6:0] P0 = 7'b1000000;
    localparam logic [6:0] P1 = 7'b1111001;
    localparam logic [6:0] P2 = 7'b0100100;
    localparam logic [6:0] P3 = 7'b0110000;
    localparam logic [6:0] P4 = 7'b0011001;
    localparam logic [6:0] P5 = 7'b0010010;
    localparam logic [6:0] P6 = 7'b0000010;
    localparam logic [6:0] P7 = 7'b1111000;
    localparam logic [6:0] P8 = 7'b0000000;
    localparam logic [6:0] P9 = 7'b0010000;
    localparam logic [6:0] PB = 7'b1111111;
    localparam logic [6:0] PX = 7'b0110110;

    localparam logic [3:0] D0 = 4'b1110;
    localparam logic [3:0] D1 = 4'b1101;
    localparam logic [3:0] D2 = 4'b1011;
    localparam logic [3:0] D3 = 4'b0111;

    logic        clk;
    logic        rst_n;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic [15:0] bcd;
    logic [3:0]  digit_err;
    logic        valid;
    logic        frame_done;

    int checks;
    int errors;
    int fd_cnt;
    int fd_at;
    int tot;

    seg7_capture #(.STABLE_CYC(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .seg        (seg),
        .an         (an),
        .bcd        (bcd),
        .digit_err  (digit_err),
        .valid      (valid),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Hold one anode/segment pattern for n cycles, noting frame_done pulses.
    task automatic show(input logic [3:0] a,
                        input logic [6:0] s,
                        input int n);
        an     = a;
        seg    = s;
        fd_cnt = 0;
        fd_at  = 0;
        for (int k = 1; k <= n; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (frame_done === 1'b1) begin
                fd_cnt++;
                if (fd_at == 0)
                    fd_at = k;
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        tot    = 0;
        rst_n  = 1'b0;
        an     = 4'hF;
        seg    = PB;
        repeat (3) @(negedge clk);
        chk("rst_bcd", 32'(bcd), 32'hFFFF);
        chk("rst_err", 32'(digit_err), 32'h0);
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_fd", 32'(frame_done), 32'h0);
        rst_n = 1'b1;

        show(D0, P3, 10); tot = fd_cnt;
        show(D1, P0, 10); tot += fd_cnt;
        show(D2, P9, 10); tot += fd_cnt;
        chk("scan_no_early_fd", 32'(tot), 32'd0);
        chk("scan_valid_before", 32'(valid), 32'h0);
        show(D3, P1, 10);
        chk("scan_fd_latency", 32'(fd_at), 32'd5);
        chk("scan_fd_count", 32'(fd_cnt), 32'd1);
        chk("scan_bcd", 32'(bcd), 32'h1903);
        chk("scan_err", 32'(digit_err), 32'h0);
        chk("scan_valid", 32'(valid), 32'h1);

        show(D0, P4, 10); tot = fd_cnt;
        show(D1, P5, 10); tot += fd_cnt;
        show(D2, P6, 3);  tot += fd_cnt;
        show(D3, P7, 10); tot += fd_cnt;
        chk("short_no_fd", 32'(tot), 32'd0);
        chk("short_bcd_hold", 32'(bcd), 32'h1903);
        show(D2, P6, 10);
        chk("short_fd_at", 32'(fd_at), 32'd5);
        chk("short_bcd", 32'(bcd), 32'h7654);

        show(D0, P5, 10); tot = fd_cnt;
        show(D1, PX, 10); tot += fd_cnt;
        show(D2, P5, 10); tot += fd_cnt;
        show(D3, PB, 10); tot += fd_cnt;
        chk("inv_fd_count", 32'(tot), 32'd1);
        chk("inv_bcd", 32'(bcd), 32'hF5F5);
        chk("inv_err", 32'(digit_err), 32'h2);

        show(D0, P4, 10);
        show(D1, P4, 6);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_bcd", 32'(bcd), 32'hFFFF);
        chk("mid_rst_err", 32'(digit_err), 32'h0);
        chk("mid_rst_valid", 32'(valid), 32'h0);
        chk("mid_rst_fd", 32'(frame_done), 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        show(D2, P2, 10); tot = fd_cnt;
        show(D3, P6, 10); tot += fd_cnt;
        chk("post_rst_no_fd", 32'(tot), 32'd0);
        chk("post_rst_valid", 32'(valid), 32'h0);
        show(D0, P4, 10); tot = fd_cnt;
        show(D1, P4, 10); tot += fd_cnt;
        chk("post_rst_fd", 32'(tot), 32'd1);
        chk("post_rst_bcd", 32'(bcd), 32'h6244);

        show(D0, P2, 10); tot = fd_cnt;
        show(D1, P3, 10); tot += fd_cnt;
        show(D2, P4, 10); tot += fd_cnt;
        show(4'b0011, P8, 8); tot += fd_cnt;
        chk("multi_no_fd", 32'(tot), 32'd0);
        show(D3, P9, 3); tot = fd_cnt;
        show(D3, P8, 1); tot += fd_cnt;
        chk("glitch_no_early", 32'(tot), 32'd0);
        show(D3, P9, 6);
        chk("glitch_fd_at", 32'(fd_at), 32'd5);
        chk("glitch_bcd", 32'(bcd), 32'h9432);

        show(D2, P1, 10); tot = fd_cnt;
        show(D0, P7, 10); tot += fd_cnt;
        show(D0, P8, 10); tot += fd_cnt;
        show(D3, P2, 10); tot += fd_cnt;
        chk("ooo_no_early", 32'(tot), 32'd0);
        show(D1, P6, 10);
        chk("ooo_fd_count", 32'(fd_cnt), 32'd1);
        chk("ooo_fd_at", 32'(fd_at), 32'd5);
        chk("ooo_bcd", 32'(bcd), 32'h2168);
        chk("ooo_valid", 32'(valid), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
